// File: rtl/spi_slave_if.sv
// SPI mode-0 slave front end: oversamples SCLK/CS_N/MOSI in the clk domain,
// deserialises MOSI bytes for the decoder and shifts the decoder's reply out on MISO.
module spi_slave_if #(
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       sclk,
  input  logic       cs_n,
  input  logic       mosi,
  output logic       miso,
  output logic       byte_sync,
  output logic [7:0] data_in,
  input  logic [7:0] data_out,
  output logic       frame_active
);

  logic [SYNC_STAGES-1:0] r_sclkSync;
  logic [SYNC_STAGES-1:0] r_csSync;
  logic [SYNC_STAGES-1:0] r_mosiSync;
  logic                   r_sclkDly;
  logic                   r_frameActive;
  logic [2:0]             r_bitCnt;
  logic [7:0]             r_rxShift;
  logic [7:0]             r_txShift;
  logic [7:0]             r_dataIn;
  logic                   r_byteSync;
  logic                   r_miso;

  logic w_sclkS;
  logic w_csS;
  logic w_mosiS;
  logic w_rise;
  logic w_fall;
  logic w_active;

  assign w_sclkS = r_sclkSync[SYNC_STAGES-1];
  assign w_csS   = r_csSync[SYNC_STAGES-1];
  assign w_mosiS = r_mosiSync[SYNC_STAGES-1];
  assign w_rise  = w_sclkS & ~r_sclkDly;
  assign w_fall  = ~w_sclkS & r_sclkDly;
  // Gating on the live synced cs_n lets a deassertion override an sclk edge seen in the same cycle.
  assign w_active = r_frameActive & ~w_csS;

  // Equal-depth chains keep sclk, cs_n and mosi aligned; reset looks like an idle bus.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sclkSync <= '0;
      r_csSync   <= '1;
      r_mosiSync <= '0;
      r_sclkDly  <= 1'b0;
    end else begin
      r_sclkSync <= {r_sclkSync[SYNC_STAGES-2:0], sclk};
      r_csSync   <= {r_csSync[SYNC_STAGES-2:0], cs_n};
      r_mosiSync <= {r_mosiSync[SYNC_STAGES-2:0], mosi};
      r_sclkDly  <= w_sclkS;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_frameActive <= 1'b0;
      r_bitCnt      <= 3'd0;
      r_rxShift     <= 8'h00;
      r_dataIn      <= 8'h00;
      r_byteSync    <= 1'b0;
    end else begin
      r_frameActive <= ~w_csS;
      r_byteSync    <= 1'b0;
      if (!w_active) begin
        r_bitCnt  <= 3'd0;
        r_rxShift <= 8'h00;
      end else if (w_rise) begin
        r_bitCnt  <= r_bitCnt + 3'd1;
        r_rxShift <= {r_rxShift[6:0], w_mosiS};
        if (r_bitCnt == 3'd7) begin
          r_dataIn   <= {r_rxShift[6:0], w_mosiS};
          r_byteSync <= 1'b1;
        end
      end
    end
  end

  // Between bytes the transmit register follows data_out so the decoder's late reply still makes the slot.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_txShift <= 8'h00;
      r_miso    <= 1'b0;
    end else begin
      if (w_active) begin
        if (w_rise && r_bitCnt == 3'd0) begin
          r_txShift <= r_txShift;
        end else if (w_fall && r_bitCnt != 3'd0) begin
          r_txShift <= {r_txShift[6:0], 1'b0};
        end else if (r_bitCnt == 3'd0) begin
          r_txShift <= data_out;
        end
      end
      r_miso <= w_active ? r_txShift[7] : 1'b0;
    end
  end

  assign miso         = r_miso;
  assign byte_sync    = r_byteSync;
  assign data_in      = r_dataIn;
  assign frame_active = r_frameActive;

endmodule

// File: tb/tb_spi_slave_if.sv
// Bench for spi_slave_if: an SPI master drives frames, a decoder model answers on data_out,
// received bytes are scoreboarded against byte_sync pulses.
module tb_spi_slave_if;
  localparam int SYNC_STAGES = 2;
  localparam int HALF = SYNC_STAGES + 3;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       sclk = 1'b0;
  logic       cs_n = 1'b1;
  logic       mosi = 1'b0;
  logic       miso;
  logic       byte_sync;
  logic [7:0] data_in;
  logic [7:0] data_out;
  logic       frame_active;
  logic [7:0] decoderNext = 8'h00;

  int         checkCount = 0;
  int         errorCount = 0;
  int         syncCount = 0;
  int         syncBase;
  logic       prevSync = 1'b0;
  logic [7:0] expRx[$];
  logic [7:0] misoByte;

  spi_slave_if #(.SYNC_STAGES(SYNC_STAGES)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .sclk(sclk),
    .cs_n(cs_n),
    .mosi(mosi),
    .miso(miso),
    .byte_sync(byte_sync),
    .data_in(data_in),
    .data_out(data_out),
    .frame_active(frame_active)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checkCount++;
    if (observed !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s: observed %0h, expected %0h", tag, observed, expected);
    end
  endtask

  task automatic waitClk(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Decoder model: presents its reply one cycle after each received byte.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) data_out <= 8'h00;
    else if (byte_sync) data_out <= decoderNext;
  end

  always @(negedge clk) begin
    if (rst_n) begin
      if (prevSync) checkOutput("syncWidth", {31'd0, byte_sync}, 32'd0);
      if (byte_sync) begin
        syncCount++;
        if (expRx.size() == 0) checkOutput("unexpectedSync", {31'd0, byte_sync}, 32'd0);
        else checkOutput("rxData", {24'd0, data_in}, {24'd0, expRx.pop_front()});
      end
      prevSync = byte_sync;
    end else begin
      prevSync = 1'b0;
    end
  end

  // Master sends the top nBits of b, mode 0, and collects MISO on each rising edge.
  task automatic applyStimulus(input logic [7:0] b, input int nBits, output logic [7:0] misoOut);
    misoOut = 8'h00;
    if (nBits == 8) expRx.push_back(b);
    for (int i = 0; i < nBits; i++) begin
      mosi = b[7-i];
      waitClk(HALF);
      sclk = 1'b1;
      misoOut = {misoOut[6:0], miso};
      waitClk(HALF);
      sclk = 1'b0;
    end
  endtask

  task automatic startFrame();
    cs_n = 1'b0;
    waitClk(HALF + 1);
    checkOutput("frameActive", {31'd0, frame_active}, 32'd1);
  endtask

  task automatic endFrame();
    waitClk(HALF);
    cs_n = 1'b1;
    waitClk(2 * HALF);
    checkOutput("frameIdle", {31'd0, frame_active}, 32'd0);
    checkOutput("pendingRx", expRx.size(), 32'd0);
  endtask

  initial begin
    waitClk(3);
    checkOutput("rstByteSync", {31'd0, byte_sync}, 32'd0);
    checkOutput("rstDataIn", {24'd0, data_in}, 32'h00);
    checkOutput("rstMiso", {31'd0, miso}, 32'd0);
    checkOutput("rstFrame", {31'd0, frame_active}, 32'd0);
    rst_n = 1'b1;
    waitClk(3);

    // Single byte, silent decoder
    syncBase = syncCount;
    startFrame();
    applyStimulus(8'h83, 8, misoByte);
    checkOutput("singleMiso", {24'd0, misoByte}, 32'h00);
    endFrame();
    checkOutput("singleSyncs", syncCount - syncBase, 32'd1);
    checkOutput("singleDataIn", {24'd0, data_in}, 32'h83);

    // Reset in the middle of a byte
    startFrame();
    applyStimulus(8'hF0, 3, misoByte);
    rst_n = 1'b0;
    #1;
    checkOutput("midRstDataIn", {24'd0, data_in}, 32'h00);
    checkOutput("midRstSync", {31'd0, byte_sync}, 32'd0);
    checkOutput("midRstMiso", {31'd0, miso}, 32'd0);
    checkOutput("midRstFrame", {31'd0, frame_active}, 32'd0);
    cs_n = 1'b1;
    waitClk(3);
    rst_n = 1'b1;
    waitClk(3);
    syncBase = syncCount;
    startFrame();
    applyStimulus(8'hA5, 8, misoByte);
    endFrame();
    checkOutput("postRstSyncs", syncCount - syncBase, 32'd1);
    checkOutput("postRstDataIn", {24'd0, data_in}, 32'hA5);

    // Two-byte frame, decoder replies 5C in byte 2
    decoderNext = 8'h5C;
    syncBase = syncCount;
    startFrame();
    applyStimulus(8'h02, 8, misoByte);
    checkOutput("twoMiso1", {24'd0, misoByte}, 32'h00);
    applyStimulus(8'h00, 8, misoByte);
    checkOutput("twoMiso2", {24'd0, misoByte}, 32'h5C);
    endFrame();
    checkOutput("twoSyncs", syncCount - syncBase, 32'd2);
    checkOutput("twoDataIn", {24'd0, data_in}, 32'h00);

    // Abort after 5 bits
    syncBase = syncCount;
    startFrame();
    applyStimulus(8'hFF, 5, misoByte);
    waitClk(HALF);
    cs_n = 1'b1;
    waitClk(2 * HALF);
    checkOutput("abortSyncs", syncCount - syncBase, 32'd0);
    checkOutput("abortDataIn", {24'd0, data_in}, 32'h00);
    startFrame();
    applyStimulus(8'h3C, 8, misoByte);
    endFrame();
    checkOutput("afterAbortSyncs", syncCount - syncBase, 32'd1);
    checkOutput("afterAbortDataIn", {24'd0, data_in}, 32'h3C);

    // Continuous four-byte frame; first slot carries the standing 5C, later slots A0
    decoderNext = 8'hA0;
    syncBase = syncCount;
    startFrame();
    for (int k = 1; k <= 4; k++) begin
      logic [7:0] txByte;
      txByte = 8'(k * 8'h11);
      applyStimulus(txByte, 8, misoByte);
      checkOutput("burstMiso", {24'd0, misoByte}, (k == 1) ? 32'h5C : 32'hA0);
    end
    endFrame();
    checkOutput("burstSyncs", syncCount - syncBase, 32'd4);
    checkOutput("burstDataIn", {24'd0, data_in}, 32'h44);

    // Spurious SCLK while deselected
    decoderNext = 8'h00;
    syncBase = syncCount;
    for (int k = 0; k < 6; k++) begin
      mosi = 1'($urandom_range(0, 1));
      waitClk(HALF);
      sclk = 1'b1;
      waitClk(2);
      checkOutput("spurMiso", {31'd0, miso}, 32'd0);
      checkOutput("spurFrame", {31'd0, frame_active}, 32'd0);
      waitClk(HALF - 2);
      sclk = 1'b0;
    end
    waitClk(2 * HALF);
    checkOutput("spurSyncs", syncCount - syncBase, 32'd0);
    startFrame();
    applyStimulus(8'h81, 8, misoByte);
    endFrame();
    checkOutput("spurNextSyncs", syncCount - syncBase, 32'd1);
    checkOutput("spurNextDataIn", {24'd0, data_in}, 32'h81);

    $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
    $finish;
  end

endmodule
